mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-ported memory bus between the core's instruction-fetch port and data load/store port. Accepts requests from both, grants one at a time, and drives a registered transaction onto the memory bus. It waits for the memory accept and response, then routes the response back to the owning requester. It sits between core_riscv (iaddr/idata, daddr/ddata_r/ddata_w/d_r/d_w) and a unified instruction/data RAM.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
MAX_WAIT, 4, consecutive data grants allowed while an instruction request is pending (used only with the optional feature)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
i_req  input  1  instruction fetch request
i_addr  input  ADDR_W  fetch address
i_gnt  output  1  fetch request accepted this cycle (combinational)
i_rvalid  output  1  fetch data valid (registered, 1-cycle pulse)
i_rdata  output  DATA_W  fetch data (registered, held until next instruction response)
d_req  input  1  data request
d_we  input  1  1 = store, 0 = load
d_addr  input  ADDR_W  data address
d_wdata  input  DATA_W  store data
d_be  input  DATA_W/8  store byte enables
d_gnt  output  1  data request accepted this cycle (combinational)
d_rvalid  output  1  load data / store ack valid (registered, 1-cycle pulse)
d_rdata  output  DATA_W  load data (registered, held until next data response)
m_req  output  1  memory request (registered)
m_we  output  1  memory write enable (registered)
m_addr  output  ADDR_W  memory address (registered)
m_wdata  output  DATA_W  memory write data (registered)
m_be  output  DATA_W/8  memory byte enables (registered; all ones for fetches and loads)
m_gnt  input  1  memory accepts m_req this cycle
m_rvalid  input  1  memory response/ack valid; asserted for both reads and writes
m_rdata  input  DATA_W  memory read data
busy  output  1  high in REQ and RESP states

Behaviour:
- Reset (async, reset=0): state IDLE, owner cleared, all outputs 0 including rdata regs, starvation counter 0. A transaction in flight is dropped. No response is forwarded after reset release.
- FSM states: IDLE, REQ, RESP. At most one outstanding memory transaction.
- IDLE, arbitration:
  - d_req wins over i_req.
  - Winner's gnt is high for that cycle only.
  - On the clock edge: addr/we/wdata/be are latched into m_* registers, owner is latched, and the FSM moves to REQ.
  - A fetch latches m_we=0 and m_be=all ones.
  - No request: stay in IDLE.
- REQ: m_req=1, m_* held stable. Go to RESP on m_gnt, else stay.
- RESP: m_req=0. On m_rvalid, go to IDLE and capture m_rdata into the owner's rdata register.
  - Owner's rvalid pulses high in the following cycle.
  - Store: d_rvalid pulses; d_rdata is not updated.
- Latency: request seen in IDLE at cycle N, m_gnt at N+1, m_rvalid at N+2 → x_rvalid at N+3. Minimum 3 cycles per access; a new grant may occur in the same cycle x_rvalid is high.
- Requester obligations:
  - Hold req and fields until gnt.
  - After gnt, the requester may change or drop its fields.
  - gnt is never given outside IDLE.
- m_rvalid or m_gnt in IDLE is ignored. m_rvalid in REQ is ignored. m_gnt in RESP is ignored.
- The non-granted requester sees gnt=0 and is served at the next IDLE arbitration if it is still requesting.

Optional Feature:
ARB_STARVE_GUARD_EN
- Defined:
  - A counter increments on each data grant made while i_req=1.
  - It clears on any instruction grant, and also when i_req=0 at arbitration.
  - When the counter equals MAX_WAIT and both requests are present, the instruction wins.
  - Counter width is clog2(MAX_WAIT+1); it saturates and never wraps.
- Undefined: strict data priority. The counter logic is not present.

Test Plan:
- Fetch only: i_req=1, i_addr=0x100, m_gnt=1 immediately, m_rvalid one cycle later with m_rdata=0x00500093 → i_gnt at N, m_addr=0x100/m_we=0/m_be=0xF at N+1, i_rvalid=1 and i_rdata=0x00500093 at N+3.
- Simultaneous: i_req=1 (0x104) and d_req=1 load 0x2000 → d_gnt first, m_addr=0x2000. After d_rvalid, i_gnt is given and m_addr=0x104.
- Store with wait states: d_we=1, d_addr=0x2004, d_wdata=0xDEADBEEF, d_be=0x3, m_gnt low for 3 cycles → m_req and fields stable for all 4 REQ cycles. d_rvalid pulses once; d_rdata is unchanged.
- Async reset asserted in RESP → outputs 0 immediately. A later m_rvalid=1 produces no i_rvalid or d_rvalid; the next request starts cleanly from IDLE.
- With ARB_STARVE_GUARD_EN and MAX_WAIT=4: d_req and i_req held continuously → 4 data grants, then 1 instruction grant, repeating. Without the macro: data grants only.
- Back-to-back fetches: i_req held, m_gnt=1, m_rvalid every response cycle → one i_rvalid every 3 cycles, with i_gnt in the same cycle as the previous i_rvalid.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the core's fetch and load/store ports onto one single-ported memory bus.
// Optional ARB_STARVE_GUARD_EN bounds how long a pending fetch can be held off by data traffic.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_be,
  input  logic                m_gnt,
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic                busy
);

  localparam int unsigned BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   owner_d;
  logic   d_win;
  logic   i_win;
  logic   starve;

  if (MAX_WAIT == 0) begin : g_bad_max_wait
    $error("mem_port_arbiter: MAX_WAIT must be at least 1");
  end

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] starve_cnt;

  assign starve = (starve_cnt == CNT_MAX);

  // Counts data grants taken while a fetch waits; saturates at MAX_WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (!i_req || i_win) begin
        starve_cnt <= '0;
      end else if (d_win && (starve_cnt != CNT_MAX)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end
`else
  assign starve = 1'b0;
`endif

  // Grants are only issued from IDLE; data wins unless a starved fetch is waiting.
  always_comb begin
    d_win = 1'b0;
    i_win = 1'b0;
    if (state == IDLE) begin
      if (d_req && !(i_req && starve)) begin
        d_win = 1'b1;
      end else if (i_req) begin
        i_win = 1'b1;
      end
    end
  end

  assign d_gnt = d_win;
  assign i_gnt = i_win;

  // Transaction FSM with registered memory-side and response-side outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      owner_d  <= 1'b0;
      busy     <= 1'b0;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_be     <= '0;
      i_rvalid <= 1'b0;
      i_rdata  <= '0;
      d_rvalid <= 1'b0;
      d_rdata  <= '0;
    end else begin
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (d_win) begin
            state   <= REQ;
            owner_d <= 1'b1;
            busy    <= 1'b1;
            m_req   <= 1'b1;
            m_we    <= d_we;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            m_be    <= d_we ? d_be : {BE_W{1'b1}};
          end else if (i_win) begin
            state   <= REQ;
            owner_d <= 1'b0;
            busy    <= 1'b1;
            m_req   <= 1'b1;
            m_we    <= 1'b0;
            m_addr  <= i_addr;
            m_wdata <= '0;
            m_be    <= {BE_W{1'b1}};
          end
        end
        REQ: begin
          if (m_gnt) begin
            state <= RESP;
            m_req <= 1'b0;
          end
        end
        RESP: begin
          if (m_rvalid) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (owner_d) begin
              d_rvalid <= 1'b1;
              // Store acks carry no data; keep the last load result visible.
              if (!m_we) begin
                d_rdata <= m_rdata;
              end
            end else begin
              i_rvalid <= 1'b1;
              i_rdata  <= m_rdata;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          m_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expectations, a monitor checks outputs.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned BE_W     = DATA_W / 8;
  localparam int unsigned MAX_WAIT = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              i_req = 1'b0;
  logic [ADDR_W-1:0] i_addr = '0;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req = 1'b0;
  logic              d_we = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [DATA_W-1:0] d_wdata = '0;
  logic [BE_W-1:0]   d_be = '0;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [BE_W-1:0]   m_be;
  logic              m_gnt = 1'b0;
  logic              m_rvalid = 1'b0;
  logic [DATA_W-1:0] m_rdata = '0;
  logic              busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .busy(busy)
  );

  typedef struct { logic d; logic [31:0] addr; logic b2b; } gnt_exp_t;
  typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; logic [3:0] be; logic chk_wdata; } mtx_exp_t;
  typedef struct { logic [31:0] data; int lat; } rsp_exp_t;

  gnt_exp_t q_gnt[$];
  mtx_exp_t q_mtx[$];
  rsp_exp_t q_i[$];
  rsp_exp_t q_d[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic [31:0] mem [logic [31:0]];
  int mem_wait = 0;
  bit mem_en = 1'b1;
  logic man_gnt = 1'b0;
  logic man_rvalid = 1'b0;
  logic [31:0] man_rdata = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: unexpected event (t=%0t)", nm, $time);
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: accepts after mem_wait cycles, responds one cycle later.
  initial begin
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] old;
    logic        we;
    logic [3:0]  be;
    forever begin
      @(posedge clk); #1;
      m_gnt = 1'b0;
      m_rvalid = 1'b0;
      if (!mem_en) begin
        m_gnt = man_gnt;
        m_rvalid = man_rvalid;
        m_rdata = man_rdata;
      end else if (m_req) begin
        for (int k = 0; k < mem_wait; k++) begin
          @(posedge clk); #1;
        end
        m_gnt = 1'b1;
        a = m_addr; we = m_we; wd = m_wdata; be = m_be;
        @(posedge clk); #1;
        m_gnt = 1'b0;
        m_rvalid = 1'b1;
        if (we) begin
          old = mem_rd(a);
          for (int b = 0; b < 4; b++) if (be[b]) old[b*8 +: 8] = wd[b*8 +: 8];
          mem[a] = old;
          m_rdata = 32'hBADC_0FFE;
        end else begin
          m_rdata = mem_rd(a);
        end
      end
    end
  end

  // Monitor: pops and compares whenever the DUT presents a grant, a transaction or a response.
  gnt_exp_t ge;
  mtx_exp_t me;
  mtx_exp_t cur_m;
  rsp_exp_t re;
  logic prev_m_req = 1'b0;
  int gnt_cyc_i = 0;
  int gnt_cyc_d = 0;
  int rv_cyc_i = -100;

  always @(negedge clk) begin
    if (i_rvalid) begin
      rv_cyc_i = cyc;
      if (q_i.size() == 0) unexpected("i_rvalid");
      else begin
        re = q_i.pop_front();
        chk("i_rdata", 64'(i_rdata), 64'(re.data));
        chk("i_latency", 64'(cyc - gnt_cyc_i), 64'(re.lat));
      end
    end
    if (d_rvalid) begin
      if (q_d.size() == 0) unexpected("d_rvalid");
      else begin
        re = q_d.pop_front();
        chk("d_rdata", 64'(d_rdata), 64'(re.data));
        chk("d_latency", 64'(cyc - gnt_cyc_d), 64'(re.lat));
      end
    end
    if (i_gnt || d_gnt) begin
      chk("gnt_onehot", 64'(i_gnt && d_gnt), 64'd0);
      if (q_gnt.size() == 0) unexpected("gnt");
      else begin
        ge = q_gnt.pop_front();
        chk("gnt_port", 64'(d_gnt), 64'(ge.d));
        chk("gnt_addr", 64'(d_gnt ? d_addr : i_addr), 64'(ge.addr));
        if (ge.b2b) chk("gnt_b2b_cycle", 64'(cyc), 64'(rv_cyc_i));
      end
      if (i_gnt) gnt_cyc_i = cyc;
      if (d_gnt) gnt_cyc_d = cyc;
    end
    if (m_req && !prev_m_req) begin
      if (q_mtx.size() == 0) unexpected("m_req");
      else begin
        me = q_mtx.pop_front();
        cur_m = me;
        chk("m_addr", 64'(m_addr), 64'(me.addr));
        chk("m_we", 64'(m_we), 64'(me.we));
        chk("m_be", 64'(m_be), 64'(me.be));
        if (me.chk_wdata) chk("m_wdata", 64'(m_wdata), 64'(me.wdata));
      end
    end else if (m_req) begin
      chk("m_addr_stable", 64'(m_addr), 64'(cur_m.addr));
      chk("m_be_stable", 64'(m_be), 64'(cur_m.be));
      if (cur_m.chk_wdata) chk("m_wdata_stable", 64'(m_wdata), 64'(cur_m.wdata));
    end
    prev_m_req = m_req;
  end

  task automatic wait_gnt(input bit dport, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (dport ? d_gnt : i_gnt) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) unexpected(dport ? "d_gnt_timeout" : "i_gnt_timeout");
  endtask

  task automatic do_fetch(input logic [31:0] a);
    bit ok;
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = a;
    wait_gnt(1'b0, ok);
    @(posedge clk); #1;
    i_req = 1'b0; i_addr = '0;
  endtask

  task automatic do_data(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    bit ok;
    @(posedge clk); #1;
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_be = be;
    wait_gnt(1'b1, ok);
    @(posedge clk); #1;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
  endtask

  task automatic exp_fetch(input logic [31:0] a, input logic [31:0] data, input logic b2b);
    q_gnt.push_back('{d: 1'b0, addr: a, b2b: b2b});
    q_mtx.push_back('{addr: a, we: 1'b0, wdata: 32'h0, be: 4'hF, chk_wdata: 1'b0});
    q_i.push_back('{data: data, lat: 3});
  endtask

  task automatic exp_load(input logic [31:0] a, input logic [31:0] data);
    q_gnt.push_back('{d: 1'b1, addr: a, b2b: 1'b0});
    q_mtx.push_back('{addr: a, we: 1'b0, wdata: 32'h0, be: 4'hF, chk_wdata: 1'b0});
    q_d.push_back('{data: data, lat: 3});
  endtask

  initial begin
    bit ok;
    bit gd;
    bit guard;
    bit is_i;
    logic [31:0] ia;
    logic [31:0] da;
`ifdef ARB_STARVE_GUARD_EN
    guard = 1'b1;
`else
    guard = 1'b0;
`endif
    mem[32'h100]  = 32'h0050_0093;
    mem[32'h104]  = 32'h0000_0013;
    mem[32'h2000] = 32'h1122_3344;

    // Reset state
    #2;
    chk("rst_m_req", 64'(m_req), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_i_rvalid", 64'(i_rvalid), 64'd0);
    chk("rst_d_rvalid", 64'(d_rvalid), 64'd0);
    chk("rst_m_addr", 64'(m_addr), 64'd0);
    chk("rst_m_be", 64'(m_be), 64'd0);
    chk("rst_i_rdata", 64'(i_rdata), 64'd0);
    chk("rst_d_rdata", 64'(d_rdata), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Fetch only
    exp_fetch(32'h100, 32'h0050_0093, 1'b0);
    do_fetch(32'h100);
    repeat (4) @(negedge clk);

    // Simultaneous: data first, then fetch
    exp_load(32'h2000, 32'h1122_3344);
    exp_fetch(32'h104, 32'h0000_0013, 1'b0);
    fork
      do_fetch(32'h104);
      do_data(1'b0, 32'h2000, 32'h0, 4'h0);
    join
    repeat (6) @(negedge clk);

    // Store with 3 wait states; d_rdata keeps the previous load value
    mem_wait = 3;
    q_gnt.push_back('{d: 1'b1, addr: 32'h2004, b2b: 1'b0});
    q_mtx.push_back('{addr: 32'h2004, we: 1'b1, wdata: 32'hDEAD_BEEF, be: 4'h3, chk_wdata: 1'b1});
    q_d.push_back('{data: 32'h1122_3344, lat: 6});
    do_data(1'b1, 32'h2004, 32'hDEAD_BEEF, 4'h3);
    repeat (8) @(negedge clk);
    mem_wait = 0;

    // Async reset while in RESP drops the transaction
    mem_en = 1'b0;
    q_gnt.push_back('{d: 1'b0, addr: 32'h300, b2b: 1'b0});
    q_mtx.push_back('{addr: 32'h300, we: 1'b0, wdata: 32'h0, be: 4'hF, chk_wdata: 1'b0});
    do_fetch(32'h300);
    @(negedge clk); man_gnt = 1'b1;
    @(negedge clk); man_gnt = 1'b0;
    @(negedge clk);
    chk("resp_busy", 64'(busy), 64'd1);
    chk("resp_m_req", 64'(m_req), 64'd0);
    reset = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_m_addr", 64'(m_addr), 64'd0);
    chk("arst_m_be", 64'(m_be), 64'd0);
    chk("arst_i_rdata", 64'(i_rdata), 64'd0);
    chk("arst_d_rdata", 64'(d_rdata), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    man_rvalid = 1'b1; man_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    man_rvalid = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_i_rdata", 64'(i_rdata), 64'd0);
    chk("post_rst_busy", 64'(busy), 64'd0);
    man_rdata = '0;
    mem_en = 1'b1;

    // Clean restart after reset
    exp_fetch(32'h100, 32'h0050_0093, 1'b0);
    do_fetch(32'h100);
    repeat (4) @(negedge clk);

    // Back-to-back fetches: each new grant lands on the previous i_rvalid
    exp_fetch(32'h500, mem_rd(32'h500), 1'b0);
    exp_fetch(32'h504, mem_rd(32'h504), 1'b1);
    exp_fetch(32'h508, mem_rd(32'h508), 1'b1);
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = 32'h500;
    for (int k = 0; k < 3; k++) begin
      wait_gnt(1'b0, ok);
      @(posedge clk); #1;
      i_addr = 32'h500 + 32'(4 * (k + 1));
    end
    i_req = 1'b0; i_addr = '0;
    repeat (4) @(negedge clk);

    // Contention: strict data priority, or 4 data grants per fetch with the guard
    ia = 32'h400; da = 32'h3000;
    for (int g = 0; g < 11; g++) begin
      is_i = (g == 10) || (guard && (g == 4 || g == 9));
      if (is_i) begin
        exp_fetch(ia, mem_rd(ia), 1'b0);
        ia = ia + 32'h4;
      end else begin
        exp_load(da, mem_rd(da));
        da = da + 32'h4;
      end
    end
    ia = 32'h400; da = 32'h3000;
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = ia;
    d_req = 1'b1; d_we = 1'b0; d_addr = da; d_be = 4'hF;
    for (int g = 0; g < 11; g++) begin
      ok = 1'b0; gd = 1'b0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (i_gnt || d_gnt) begin
          ok = 1'b1; gd = d_gnt;
          break;
        end
      end
      if (!ok) unexpected("contention_gnt_timeout");
      @(posedge clk); #1;
      if (gd) begin da = da + 32'h4; d_addr = da; end
      else begin ia = ia + 32'h4; i_addr = ia; end
      if (g == 9) d_req = 1'b0;
      if (g == 10) i_req = 1'b0;
    end
    d_addr = '0; d_be = '0; i_addr = '0;

    // Drain and confirm every expectation was consumed
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (q_gnt.size() == 0 && q_mtx.size() == 0 && q_i.size() == 0 && q_d.size() == 0) break;
    end
    chk("left_gnt", 64'(q_gnt.size()), 64'd0);
    chk("left_mtx", 64'(q_mtx.size()), 64'd0);
    chk("left_i", 64'(q_i.size()), 64'd0);
    chk("left_d", 64'(q_d.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
